// File: rtl/alu_pkg.sv
// Shared types for the ALU issue decoder: ALU op codes, RV32I opcodes and the
// decoded-entry record handed from the decode LUT to the issue stage.
package alu_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluSll  = 4'b0010,
    AluSlt  = 4'b0011,
    AluSltu = 4'b0100,
    AluXor  = 4'b0101,
    AluSrl  = 4'b0110,
    AluSra  = 4'b0111,
    AluOr   = 4'b1000,
    AluAnd  = 4'b1001
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_t     op;
    logic        src2_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } dec_t;

  // Shared funct3 map of OP / OP-IMM; alt selects sub/sra on the two alt-capable slots.
  function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_decoder_if.sv
// Fetch-side and execute-side handshake bundle of the ALU issue decoder.
// slave: the decoder; master: the fetch/execute environment driving it.
interface alu_issue_decoder_if #(
  parameter int unsigned PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_op;
  logic            out_src2_imm;
  logic [31:0]     out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_illegal;
  logic [PC_W-1:0] out_pc;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_alu_op, out_src2_imm, out_imm, out_rs1, out_rs2, out_rd,
           out_reg_write, out_illegal, out_pc
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_alu_op, out_src2_imm, out_imm, out_rs1, out_rs2, out_rd,
           out_reg_write, out_illegal, out_pc
  );
endinterface

// File: rtl/alu_op_lut.sv
// Purely combinational RV32I word -> decoded ALU entry.
// Register index fields are passed through raw from the encoding (LUI forces rs1 to 0).
module alu_op_lut
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  // Decode per opcode, then collapse anything unsupported to a harmless illegal entry.
  always_comb begin
    dec     = '0;
    legal   = 1'b1;
    dec.op  = AluAdd;
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd  = instr[11:7];
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.op        = f3_to_op(funct3, funct7[5]);
        dec.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.src2_imm  = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
        if (funct3 == 3'b001) begin
          legal   = (funct7 == F7_BASE);
          dec.imm = imm_sh;
        end else if (funct3 == 3'b101) begin
          legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec.imm = imm_sh;
        end
        // No subi: only the shift slot honours the alt bit.
        dec.op = f3_to_op(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OPC_LOAD: begin
        legal         = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_i;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        legal        = funct3 inside {3'b000, 3'b001, 3'b010};
        dec.src2_imm = 1'b1;
        dec.imm      = imm_s;
      end
      OPC_BRANCH: begin
        legal   = (funct3[2:1] != 2'b01);
        dec.imm = imm_b;
        case (funct3[2:1])
          2'b00:   dec.op = AluSub;
          2'b10:   dec.op = AluSlt;
          2'b11:   dec.op = AluSltu;
          default: dec.op = AluAdd;
        endcase
      end
      OPC_JALR: begin
        legal         = (funct3 == 3'b000);
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_i;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_j;
        dec.reg_write = 1'b1;
      end
      OPC_LUI: begin
        dec.rs1       = 5'd0;
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.op        = AluAdd;
      dec.src2_imm  = 1'b0;
      dec.imm       = '0;
      dec.reg_write = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// ALU issue decoder: decodes fetched RV32I words and issues them to execute through an
// output register backed by a one-entry skid register, so in_ready can come from a flop
// without losing throughput.
// Optional perf counters are built only when ALU_ISSUE_PERF_EN is defined.
module alu_issue_decoder
  import alu_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_decoder_if.slave bus,
  output logic [CNT_W-1:0]   cnt_decoded,
  output logic [CNT_W-1:0]   cnt_illegal
);

  typedef struct packed {
    dec_t            dec;
    logic [PC_W-1:0] pc;
  } entry_t;

  dec_t   in_dec;
  entry_t in_entry;
  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q;
  logic   accept, xfer, out_free;

  alu_op_lut u_lut (
    .instr (bus.in_instr),
    .dec   (in_dec)
  );

  assign in_entry = '{dec: in_dec, pc: bus.in_pc};
  assign accept   = bus.in_valid && in_ready_q;
  assign xfer     = out_valid_q && bus.out_ready;
  assign out_free = !out_valid_q || xfer;

  // Next-state of the output/skid pair; skid only fills while the output is stalled,
  // and in_ready is low whenever skid is full, so an accept never meets a full skid.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // Stage registers; in_ready is registered as the complement of next skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_alu_op    = out_q.dec.op;
  assign bus.out_src2_imm  = out_q.dec.src2_imm;
  assign bus.out_imm       = out_q.dec.imm;
  assign bus.out_rs1       = out_q.dec.rs1;
  assign bus.out_rs2       = out_q.dec.rs2;
  assign bus.out_rd        = out_q.dec.rd;
  assign bus.out_reg_write = out_q.dec.reg_write;
  assign bus.out_illegal   = out_q.dec.illegal;
  assign bus.out_pc        = out_q.pc;

`ifdef ALU_ISSUE_PERF_EN
  logic [CNT_W-1:0] cnt_decoded_q, cnt_illegal_q;

  // Count entries handed to execute; a transfer in a flush cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_decoded_q <= '0;
      cnt_illegal_q <= '0;
    end else if (xfer) begin
      cnt_decoded_q <= cnt_decoded_q + CNT_W'(1);
      if (out_q.dec.illegal) cnt_illegal_q <= cnt_illegal_q + CNT_W'(1);
    end
  end

  assign cnt_decoded = cnt_decoded_q;
  assign cnt_illegal = cnt_illegal_q;
`else
  assign cnt_decoded = '0;
  assign cnt_illegal = '0;
`endif

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench for alu_issue_decoder with a FIFO scoreboard of hand-decoded entries.
module tb_alu_issue_decoder;

  typedef struct packed {
    logic [3:0]  op;
    logic        src2_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cnt_decoded, cnt_illegal;

  int   checks = 0;
  int   errors = 0;
  int   n_xfer = 0;
  int   n_ill  = 0;
  ent_t q[$];

  logic [31:0] ins [12];
  ent_t        tbl [12];

  alu_issue_decoder_if #(.PC_W(32)) bus ();

  alu_issue_decoder #(.PC_W(32), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cnt_decoded (cnt_decoded),
    .cnt_illegal (cnt_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [3:0] op, input logic s, input logic [31:0] imm,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                              input logic rw, input logic ill);
    ent_t e;
    e = '{op: op, src2_imm: s, imm: imm, rs1: r1, rs2: r2, rd: rd, reg_write: rw,
          illegal: ill, pc: 32'h0};
    return e;
  endfunction

  function automatic ent_t observe();
    ent_t o;
    o.op        = bus.out_alu_op;
    o.src2_imm  = bus.out_src2_imm;
    o.imm       = bus.out_imm;
    o.rs1       = bus.out_rs1;
    o.rs2       = bus.out_rs2;
    o.rd        = bus.out_rd;
    o.reg_write = bus.out_reg_write;
    o.illegal   = bus.out_illegal;
    o.pc        = bus.out_pc;
    return o;
  endfunction

  function automatic ent_t expect_of(input int idx, input logic [31:0] pc);
    ent_t e;
    e    = tbl[idx];
    e.pc = pc;
    return e;
  endfunction

  // Scoreboard: every transfer must match the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      chk("out_expected", 128'(q.size() != 0), 128'(1));
      if (q.size() != 0) begin
        ent_t e;
        e = q.pop_front();
        chk("out_entry", 128'(observe()), 128'(e));
        n_xfer++;
        if (e.illegal) n_ill++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; record it as expected once in_ready shows it will be taken.
  task automatic push(input int idx, input logic [31:0] pc, input bit must_ready);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins[idx];
    bus.in_pc    = pc;
    @(negedge clk);
    if (must_ready) chk("in_ready_high", 128'(bus.in_ready), 128'(1));
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready === 1'b1) q.push_back(expect_of(idx, pc));
    else chk("accept_timeout", 128'(bus.in_ready), 128'(1));
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(output int n);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", 128'(q.size()), 128'(0));
    step();
  endtask

  task automatic chk_counters(input string tag);
`ifdef ALU_ISSUE_PERF_EN
    chk({tag, "_decoded"}, 128'(cnt_decoded), 128'(n_xfer));
    chk({tag, "_illegal"}, 128'(cnt_illegal), 128'(n_ill));
`else
    chk({tag, "_decoded"}, 128'(cnt_decoded), 128'(0));
    chk({tag, "_illegal"}, 128'(cnt_illegal), 128'(0));
`endif
  endtask

  initial begin
    int n;
    ins[0]  = 32'h002081B3; tbl[0]  = mk(4'h0, 1'b0, 32'h0,        5'd1, 5'd2,  5'd3,  1'b1, 1'b0);
    ins[1]  = 32'h402081B3; tbl[1]  = mk(4'h1, 1'b0, 32'h0,        5'd1, 5'd2,  5'd3,  1'b1, 1'b0);
    ins[2]  = 32'h40335293; tbl[2]  = mk(4'h7, 1'b1, 32'h3,        5'd6, 5'd3,  5'd5,  1'b1, 1'b0);
    ins[3]  = 32'h0020E063; tbl[3]  = mk(4'h4, 1'b0, 32'h0,        5'd1, 5'd2,  5'd0,  1'b0, 1'b0);
    ins[4]  = 32'h0041D463; tbl[4]  = mk(4'h3, 1'b0, 32'h8,        5'd3, 5'd4,  5'd8,  1'b0, 1'b0);
    ins[5]  = 32'h00000000; tbl[5]  = mk(4'h0, 1'b0, 32'h0,        5'd0, 5'd0,  5'd0,  1'b0, 1'b1);
    ins[6]  = 32'hFFC12383; tbl[6]  = mk(4'h0, 1'b1, 32'hFFFFFFFC, 5'd2, 5'd28, 5'd7,  1'b1, 1'b0);
    ins[7]  = 32'h123454B7; tbl[7]  = mk(4'h0, 1'b1, 32'h12345000, 5'd0, 5'd3,  5'd9,  1'b1, 1'b0);
    ins[8]  = 32'h00532623; tbl[8]  = mk(4'h0, 1'b1, 32'hC,        5'd6, 5'd5,  5'd12, 1'b0, 1'b0);
    ins[9]  = 32'h023100B3; tbl[9]  = mk(4'h0, 1'b0, 32'h0,        5'd2, 5'd3,  5'd1,  1'b0, 1'b1);
    ins[10] = 32'h40309113; tbl[10] = mk(4'h0, 1'b0, 32'h0,        5'd1, 5'd3,  5'd2,  1'b0, 1'b1);
    ins[11] = 32'hFFF24213; tbl[11] = mk(4'h5, 1'b1, 32'hFFFFFFFF, 5'd4, 5'd31, 5'd4,  1'b1, 1'b0);

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_fields", 128'(observe()), 128'(0));
    chk_counters("rst_cnt");
    step();
    rst_n = 1'b1;
    step();

    // Decode table, streamed back to back: in_ready must stay high every cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) push(i, 32'h1000 + 32'(4 * i), 1'b1);
    wait_drain(n);
    chk("stream_drain_cycles", 128'(n <= 2), 128'(1));

    // Backpressure: three words offered, two taken, third refused
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = ins[2];
    bus.in_pc     = 32'h2000;
    @(negedge clk);
    chk("bp_ready_w0", 128'(bus.in_ready), 128'(1));
    q.push_back(expect_of(2, 32'h2000));
    step();
    bus.in_instr = ins[7];
    bus.in_pc    = 32'h2004;
    @(negedge clk);
    chk("bp_ready_w1", 128'(bus.in_ready), 128'(1));
    q.push_back(expect_of(7, 32'h2004));
    step();
    bus.in_instr = ins[11];
    bus.in_pc    = 32'h2008;
    @(negedge clk);
    chk("bp_ready_w2", 128'(bus.in_ready), 128'(0));
    chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_hold", 128'(observe()), 128'(expect_of(2, 32'h2000)));
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_still_low", 128'(bus.in_ready), 128'(0));
    step();
    chk("bp_ready_back", 128'(bus.in_ready), 128'(1));
    wait_drain(n);

    // Flush with skid full; the word offered in the flush cycle is dropped
    bus.out_ready = 1'b0;
    push(0, 32'h3000, 1'b1);
    push(4, 32'h3004, 1'b1);
    chk("fl_skid_full", 128'(bus.in_ready), 128'(0));
    bus.in_valid = 1'b1;
    bus.in_instr = ins[8];
    bus.in_pc    = 32'h3008;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    chk("fl_out_valid", 128'(bus.out_valid), 128'(0));
    chk("fl_in_ready", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Flush with a same-cycle transfer and an offered word: transfer counts, word dropped
    push(8, 32'h3100, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_instr = ins[9];
    bus.in_pc    = 32'h3104;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl2_sb_empty", 128'(q.size()), 128'(0));
    q.delete();
    chk("fl2_out_valid", 128'(bus.out_valid), 128'(0));
    repeat (3) step();
    push(1, 32'h3200, 1'b1);
    wait_drain(n);
    step();
    chk_counters("cnt_main");

    // Asynchronous reset mid-stream with both registers full
    bus.out_ready = 1'b0;
    push(11, 32'h4000, 1'b1);
    push(1, 32'h4004, 1'b1);
    chk("pre_rst_ready", 128'(bus.in_ready), 128'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("mid_rst_fields", 128'(observe()), 128'(0));
    q.delete();
    n_xfer = 0;
    n_ill  = 0;
    chk_counters("mid_rst_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    push(5, 32'h5000, 1'b1);
    wait_drain(n);
    step();
    chk_counters("cnt_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
